ov7670_capture_ms: RTL and testbench

Parametrised multi-format capture front end for the OV7670 camera port. It runs on the camera pixel clock and assembles byte pairs into pixels in one of four formats. It can optionally decimate the frame 2:1 in both axes and produces linear frame-buffer write strobes. Frame arming, frame-done and frame counting let the bus-side controller run single-shot or continuous capture; sticky error flags report malformed frames.

---
 rtl/ov7670_capture_ms.sv | 231 +++++++++++++++++++++++
 tb/tb_ov7670_capture_ms.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ov7670_capture_ms.sv
// ov7670_capture_ms: OV7670 camera-port capture front end, pixel-clock domain.
//
// Assembles byte pairs into 16-bit pixels in one of four formats. It can optionally
// decimate 2:1 in both axes. It issues linear frame-buffer write strobes
// (PAddress = dest_y*H_OUT + dest_x), built with a running line base rather than
// a multiplier.
//
// Ports:
//   Pclock, Reset            pixel clock (rising edge), synchronous active-high reset
//   Vsync, Href, Data        camera sync and byte bus
//   Fmt, Decim               pixel format / decimation, latched when a frame starts
//   Arm, Continuous          single-shot request / automatic re-arm after each frame
//   ClearErr                 clears the sticky error flags
//   PixelData, PAddress      registered pixel and its write address
//   WPixel                   one-cycle write strobe per kept pixel
//   FrameDone, FrameCount    end-of-frame pulse and wrapping completed-frame count
//   Busy                     capture state machine is not idle
//   Err                      sticky: [0] byte phase, [1] overflow, [2] frame size
//
// H_ACTIVE is expected to be even when Decim is used, so H_ACTIVE>>1 kept pixels fit a line.
module ov7670_capture_ms #(
  parameter int unsigned H_ACTIVE = 176,
  parameter int unsigned V_ACTIVE = 144,
  parameter int unsigned ADDR_W   = 15
) (
  input  logic              Pclock,
  input  logic              Reset,
  input  logic              Vsync,
  input  logic              Href,
  input  logic [7:0]        Data,
  input  logic [1:0]        Fmt,
  input  logic              Decim,
  input  logic              Arm,
  input  logic              Continuous,
  input  logic              ClearErr,
  output logic [15:0]       PixelData,
  output logic [ADDR_W-1:0] PAddress,
  output logic              WPixel,
  output logic              FrameDone,
  output logic              Busy,
  output logic [7:0]        FrameCount,
  output logic [2:0]        Err
);

  // Source counters are one bit wider than needed so over-long lines/frames stay
  // distinguishable from the active limits; they also saturate rather than wrap.
  localparam int unsigned XW = $clog2(H_ACTIVE + 1) + 1;
  localparam int unsigned YW = $clog2(V_ACTIVE + 1) + 1;
  localparam logic [XW-1:0] HLimit = XW'(H_ACTIVE);
  localparam logic [YW-1:0] VLimit = YW'(V_ACTIVE);

  typedef enum logic [1:0] {StIdle, StWaitVsHigh, StWaitVsLow, StActive} state_e;

  state_e            state_q, state_d;
  logic              vsync_q, vsync_d;
  logic              href_q, href_d;
  logic              phase_q, phase_d;
  logic [7:0]        b0_q, b0_d;
  logic [XW-1:0]     src_x_q, src_x_d;
  logic [YW-1:0]     src_y_q, src_y_d;
  logic [ADDR_W-1:0] dest_x_q, dest_x_d;
  logic [ADDR_W-1:0] line_base_q, line_base_d;
  logic [1:0]        fmt_q, fmt_d;
  logic              decim_q, decim_d;
  logic [15:0]       pixel_q, pixel_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wpixel_q, wpixel_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic [7:0]        count_q, count_d;
  logic [2:0]        err_q, err_d;

  logic              vs_rise, hs_fall;
  logic [2:0]        err_set;
  logic [ADDR_W-1:0] h_out;
  logic              x_over, y_over, pix_keep, line_keep;

  function automatic logic [15:0] fmt_pixel(input logic [1:0] f, input logic [7:0] b0,
                                             input logic [7:0] b1);
    logic [15:0] p;
    unique case (f)
      2'd0:    p = {b0, b1};
      2'd1:    p = {4'h0, b0[3:0], b1};
      2'd2:    p = {8'h00, b0[7:5], b0[2:0], b1[4:3]};
      default: p = {8'h00, b0};
    endcase
    return p;
  endfunction

  assign vs_rise   = Vsync & ~vsync_q;
  assign hs_fall   = ~Href & href_q;
  assign h_out     = decim_q ? ADDR_W'(H_ACTIVE >> 1) : ADDR_W'(H_ACTIVE);
  assign x_over    = (src_x_q >= HLimit);
  assign y_over    = (src_y_q >= VLimit);
  assign pix_keep  = ~decim_q | (~src_x_q[0] & ~src_y_q[0]);
  assign line_keep = ~y_over & (~decim_q | ~src_y_q[0]);

  always_comb begin
    state_d     = state_q;
    vsync_d     = Vsync;
    // Line history only matters inside a frame; holding it low elsewhere avoids a
    // spurious line end on the first active cycle.
    href_d      = (state_q == StActive) & Href;
    phase_d     = phase_q;
    b0_d        = b0_q;
    src_x_d     = src_x_q;
    src_y_d     = src_y_q;
    dest_x_d    = dest_x_q;
    line_base_d = line_base_q;
    fmt_d       = fmt_q;
    decim_d     = decim_q;
    pixel_d     = pixel_q;
    addr_d      = addr_q;
    wpixel_d    = 1'b0;
    done_d      = 1'b0;
    count_d     = count_q;
    err_set     = 3'b000;

    unique case (state_q)
      StIdle: begin
        if (Arm) state_d = StWaitVsHigh;
      end
      StWaitVsHigh: begin
        if (Vsync) state_d = StWaitVsLow;
      end
      StWaitVsLow: begin
        if (!Vsync) begin
          state_d     = StActive;
          fmt_d       = Fmt;
          decim_d     = Decim;
          src_x_d     = '0;
          src_y_d     = '0;
          dest_x_d    = '0;
          line_base_d = '0;
          phase_d     = 1'b0;
        end
      end
      StActive: begin
        if (vs_rise) begin
          // Frame end takes priority over any byte or line event this cycle.
          done_d  = 1'b1;
          count_d = count_q + 8'd1;
          if (src_y_q != VLimit) err_set[2] = 1'b1;
          state_d = Continuous ? StWaitVsLow : StIdle;
        end else if (Href && !Vsync) begin
          if (!phase_q) begin
            b0_d    = Data;
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            src_x_d = (src_x_q == '1) ? src_x_q : src_x_q + XW'(1);
            if (x_over || y_over) begin
              err_set[1] = 1'b1;
            end else if (pix_keep) begin
              wpixel_d = 1'b1;
              pixel_d  = fmt_pixel(fmt_q, b0_q, Data);
              addr_d   = line_base_q + dest_x_q;
              dest_x_d = dest_x_q + ADDR_W'(1);
            end
          end
        end else if (hs_fall) begin
          if (phase_q) err_set[0] = 1'b1;
          if (src_x_q != HLimit) err_set[2] = 1'b1;
          src_y_d = (src_y_q == '1) ? src_y_q : src_y_q + YW'(1);
          src_x_d = '0;
          phase_d = 1'b0;
          if (line_keep) begin
            dest_x_d    = '0;
            line_base_d = line_base_q + h_out;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // A fresh error beats a simultaneous clear.
    err_d  = (ClearErr ? 3'b000 : err_q) | err_set;
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge Pclock) begin
    if (Reset) begin
      state_q     <= StIdle;
      vsync_q     <= 1'b0;
      href_q      <= 1'b0;
      phase_q     <= 1'b0;
      b0_q        <= '0;
      src_x_q     <= '0;
      src_y_q     <= '0;
      dest_x_q    <= '0;
      line_base_q <= '0;
      fmt_q       <= '0;
      decim_q     <= 1'b0;
      pixel_q     <= '0;
      addr_q      <= '0;
      wpixel_q    <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      count_q     <= '0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      vsync_q     <= vsync_d;
      href_q      <= href_d;
      phase_q     <= phase_d;
      b0_q        <= b0_d;
      src_x_q     <= src_x_d;
      src_y_q     <= src_y_d;
      dest_x_q    <= dest_x_d;
      line_base_q <= line_base_d;
      fmt_q       <= fmt_d;
      decim_q     <= decim_d;
      pixel_q     <= pixel_d;
      addr_q      <= addr_d;
      wpixel_q    <= wpixel_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      count_q     <= count_d;
      err_q       <= err_d;
    end
  end

  assign PixelData  = pixel_q;
  assign PAddress   = addr_q;
  assign WPixel     = wpixel_q;
  assign FrameDone  = done_q;
  assign Busy       = busy_q;
  assign FrameCount = count_q;
  assign Err        = err_q;

endmodule

// File: tb/tb_ov7670_capture_ms.sv
// Scoreboard bench for ov7670_capture_ms, run with a reduced frame size so that
// many frames fit a short run. The driver pushes expected writes computed from
// source coordinates; a monitor pops them on every WPixel.
module tb_ov7670_capture_ms;
  localparam int unsigned H  = 16;
  localparam int unsigned V  = 10;
  localparam int unsigned AW = 8;

  logic          Pclock = 1'b0;
  logic          Reset, Vsync, Href, Arm, Decim, Continuous, ClearErr;
  logic [7:0]    Data;
  logic [1:0]    Fmt;
  logic [15:0]   PixelData;
  logic [AW-1:0] PAddress;
  logic          WPixel, FrameDone, Busy;
  logic [7:0]    FrameCount;
  logic [2:0]    Err;

  always #5 Pclock = ~Pclock;

  ov7670_capture_ms #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
    .Pclock(Pclock), .Reset(Reset), .Vsync(Vsync), .Href(Href), .Data(Data), .Fmt(Fmt),
    .Decim(Decim), .Arm(Arm), .Continuous(Continuous), .ClearErr(ClearErr),
    .PixelData(PixelData), .PAddress(PAddress), .WPixel(WPixel), .FrameDone(FrameDone),
    .Busy(Busy), .FrameCount(FrameCount), .Err(Err)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [15:0]   data;
  } pix_t;

  pix_t       exp_q[$];
  pix_t       mon_e;
  int         vectors = 0, miscompares = 0;
  int         done_seen = 0, exp_done = 0, exp_frames = 0;
  bit         m_active = 0, m_armed = 0, m_decim = 0;
  int         m_fmt = 0, m_y = 0;
  logic [2:0] exp_err = 3'b000;
  bit         fd_prev = 0;
  logic [7:0] fix0 [3];
  logic [7:0] fix1 [3];

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Pixel format from the byte rules, written as plain arithmetic.
  function automatic int ref_fmt(input int f, input int b0, input int b1);
    case (f)
      0:       return b0 * 256 + b1;
      1:       return (b0 % 16) * 256 + b1;
      2:       return (b0 / 32) * 32 + (b0 % 8) * 4 + (b1 / 8) % 4;
      default: return b0;
    endcase
  endfunction

  // Monitor: every write strobe must match the oldest expected pixel.
  always @(negedge Pclock) begin
    if (WPixel) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write",
                 PAddress, PixelData);
      end else begin
        mon_e = exp_q.pop_front();
        check("write_addr", int'(PAddress), int'(mon_e.addr));
        check("write_data", int'(PixelData), int'(mon_e.data));
      end
    end
    if (FrameDone) begin
      done_seen++;
      check("done_width", int'(fd_prev), 0);
    end
    fd_prev = FrameDone;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge Pclock);
  endtask

  task automatic do_arm();
    @(negedge Pclock);
    Arm = 1'b1;
    @(negedge Pclock);
    Arm = 1'b0;
    if (!m_active && !m_armed) m_armed = 1;
  endtask

  task automatic vs_pulse();
    @(negedge Pclock);
    Vsync = 1'b1;
    Href  = 1'b0;
    if (m_active) begin
      if (m_y != V) exp_err[2] = 1'b1;
      exp_frames++;
      exp_done++;
      m_active = 0;
      m_armed  = Continuous;
    end
    tick(3);
    Vsync = 1'b0;
    if (m_armed) begin
      m_active = 1;
      m_armed  = 0;
      m_fmt    = int'(Fmt);
      m_decim  = Decim;
      m_y      = 0;
    end
    tick(3);
  endtask

  task automatic send_line(input int nbytes, input bit fix, input logic [7:0] f0,
                           input logic [7:0] f1);
    int b0v, x;
    pix_t p;
    b0v = 0;
    for (int b = 0; b < nbytes; b++) begin
      @(negedge Pclock);
      Href = 1'b1;
      if (fix && b == 0) Data = f0;
      else if (fix && b == 1) Data = f1;
      else Data = 8'($urandom);
      if (m_active) begin
        if (b % 2 == 0) begin
          b0v = int'(Data);
        end else begin
          x = b / 2;
          if (x >= H || m_y >= V) begin
            exp_err[1] = 1'b1;
          end else if (!m_decim || (x % 2 == 0 && m_y % 2 == 0)) begin
            p.addr = AW'((m_y >> m_decim) * (H >> m_decim) + (x >> m_decim));
            p.data = 16'(ref_fmt(m_fmt, b0v, int'(Data)));
            exp_q.push_back(p);
          end
        end
      end
    end
    @(negedge Pclock);
    Href = 1'b0;
    if (m_active) begin
      if (nbytes % 2 != 0) exp_err[0] = 1'b1;
      if (nbytes / 2 != H) exp_err[2] = 1'b1;
      m_y++;
    end
    tick(3);
  endtask

  task automatic send_lines(input int n);
    for (int l = 0; l < n; l++) send_line(2 * H, 0, 8'h00, 8'h00);
  endtask

  task automatic check_frame(input string tag);
    check({tag, "_count"}, int'(FrameCount), exp_frames % 256);
    check({tag, "_err"}, int'(Err), int'(exp_err));
    check({tag, "_busy"}, int'(Busy), int'(m_active || m_armed));
    check({tag, "_done"}, done_seen, exp_done);
    check({tag, "_pending"}, exp_q.size(), 0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_wpixel"}, int'(WPixel), 0);
    check({tag, "_done"}, int'(FrameDone), 0);
    check({tag, "_busy"}, int'(Busy), 0);
    check({tag, "_count"}, int'(FrameCount), 0);
    check({tag, "_err"}, int'(Err), 0);
    check({tag, "_addr"}, int'(PAddress), 0);
    check({tag, "_pixel"}, int'(PixelData), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    fix0 = '{8'hAB, 8'hF8, 8'h5A};
    fix1 = '{8'hCD, 8'h1F, 8'h80};
    Reset = 1'b1; Vsync = 1'b0; Href = 1'b0; Data = 8'h00; Fmt = 2'd0; Decim = 1'b0;
    Arm = 1'b0; Continuous = 1'b0; ClearErr = 1'b0;
    tick(3);
    Reset = 1'b0;
    check_zero("reset");

    // Full RGB565 frame with a fixed first pixel.
    do_arm();
    check("armed_busy", int'(Busy), 1);
    vs_pulse();
    send_line(2 * H, 1, 8'hF8, 8'h1F);
    send_lines(V - 1);
    vs_pulse();
    check_frame("fmt0");

    // Remaining formats, each with a known first pixel.
    for (int f = 1; f < 4; f++) begin
      Fmt = 2'(f);
      do_arm();
      vs_pulse();
      send_line(2 * H, 1, fix0[f-1], fix1[f-1]);
      send_lines(V - 1);
      vs_pulse();
      check_frame("fmtn");
    end

    // Decimated frame.
    Fmt = 2'($urandom_range(0, 3));
    Decim = 1'b1;
    do_arm();
    vs_pulse();
    Decim = 1'b0;
    send_lines(V);
    vs_pulse();
    check_frame("decim");

    // Malformed frame: one odd-length line and two extra lines.
    Fmt = 2'd0;
    do_arm();
    vs_pulse();
    send_line(2 * H + 1, 0, 8'h00, 8'h00);
    send_lines(V + 1);
    vs_pulse();
    check_frame("bad");
    @(negedge Pclock);
    ClearErr = 1'b1;
    @(negedge Pclock);
    ClearErr = 1'b0;
    exp_err = 3'b000;
    check("clear_err", int'(Err), 0);

    // Continuous capture over three frames, format change mid-frame 2.
    d0 = done_seen;
    Continuous = 1'b1;
    Fmt = 2'd2;
    do_arm();
    vs_pulse();
    send_lines(V);
    vs_pulse();
    send_lines(V / 2);
    Fmt = 2'd3;
    send_lines(V - V / 2);
    vs_pulse();
    send_lines(V / 2);
    Continuous = 1'b0;
    send_lines(V - V / 2);
    vs_pulse();
    check("cont_pulses", done_seen - d0, 3);
    check_frame("cont");

    // Reset mid-frame, with an Arm attempt while busy beforehand.
    Fmt = 2'($urandom_range(0, 3));
    do_arm();
    vs_pulse();
    send_lines(4);
    do_arm();
    send_lines(2);
    check("pre_reset_busy", int'(Busy), 1);
    check("pre_reset_pending", exp_q.size(), 0);
    @(negedge Pclock);
    Reset = 1'b1;
    @(negedge Pclock);
    Reset = 1'b0;
    m_active = 0; m_armed = 0; exp_frames = 0; exp_err = 3'b000;
    check_zero("midreset");

    // Capture resumes normally after reset.
    do_arm();
    vs_pulse();
    send_lines(V);
    vs_pulse();
    check_frame("after_reset");

    tick(4);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
